mptw_arbiter: RTL and testbench
===============================

// Module: mptw_arbiter
// PURPOSE
//  Shares one MPT (memory protection table) walker between NR_PORTS requesters: the store buffer's commit drain and the load unit.
//  Per-port enable/valid/allow handshake, as driven by the store buffer: mptw_enable_o -> mptw_valid_i/mptw_allow_i.
//  Round-robin arbitration, one walk in flight. The result is held registered until the owner consumes it.
//  Sits in the LSU between the requesters and the MPT walker.
// PARAMETERS
//  NR_PORTS  2   number of requesters; port 0 = store buffer, port 1 = load unit
//  PLEN      56  physical address width
// PORTS
//  clk_i           in   1                clock
//  rst_i           in   1                synchronous reset, active-high
//  flush_i         in   1                abort the walk in flight; no new grant this cycle
//  req_enable_i    in   NR_PORTS         per-port walk request; level, held until serviced
//  req_paddr_i     in   NR_PORTS*PLEN    per-port physical address
//  req_store_i     in   NR_PORTS         per-port access type (1 = write)
//  req_done_i      in   NR_PORTS         owner consumed result (e.g. dcache data_gnt, or result used)
//  req_valid_o     out  NR_PORTS         result valid; one-hot, owner only
//  req_allow_o     out  NR_PORTS         access permitted; meaningful only with req_valid_o
//  walk_req_o      out  1                walk request to walker
//  walk_paddr_o    out  PLEN             latched address of the owner
//  walk_store_o    out  1                latched access type of the owner
//  walk_gnt_i      in   1                walker accepted walk_req_o
//  walk_valid_i    in   1                walker result valid; single-cycle pulse
//  walk_allow_i    in   1                walker permission result
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, owner=0, abort=0.
//   All outputs are 0: req_valid_o, req_allow_o, walk_req_o, walk_paddr_o, walk_store_o.
//  All outputs are registered or decoded from state only; none depends combinationally on a *_i port.
//  FSM:
//   IDLE: if !flush_i and any req_enable_i, pick the first set port at or after rr_ptr (wrapping at NR_PORTS).
//    Latch owner, paddr and store -> REQ. rr_ptr <= owner+1 (mod NR_PORTS).
//   REQ: walk_req_o=1, held until walk_gnt_i; it is never retracted.
//    gnt & walk_valid_i in the same cycle -> RESP, or IDLE if aborting.
//    gnt alone -> WAIT, or DRAIN if aborting.
//   WAIT: on walk_valid_i, latch allow <= walk_allow_i -> RESP.
//    flush_i or owner enable low -> DRAIN.
//   RESP: req_valid_o[owner]=1, req_allow_o[owner]=allow.
//    Leave to IDLE on req_done_i[owner] or flush_i.
//    Owner enable dropping does NOT release RESP: the store buffer deasserts enable while it sees valid.
//   DRAIN: outputs idle. Wait for walk_valid_i, discard the result -> IDLE.
//  abort flag: set in REQ on flush_i or on owner enable low; cleared on leaving REQ.
//  Latency: enable seen at cycle 0 -> walk_req_o at cycle 1.
//   Best case is gnt and walk_valid_i both at cycle 1 -> req_valid_o at cycle 2.
//   A walker responding in the cycle after gnt gives req_valid_o at cycle 3.
//  Back-to-back: RESP -> IDLE costs one cycle; the next grant is made in IDLE.
//  Fairness: with all ports requesting continuously, grants rotate 0,1,..,NR_PORTS-1.
//  Boundaries:
//   req_done_i from a non-owner is ignored.
//   walk_valid_i in IDLE/RESP is ignored.
//   req_done_i and flush_i together in RESP -> IDLE; identical to either alone.
//   flush_i in IDLE blocks the grant for that cycle only.
//   Reset mid-walk -> IDLE immediately. The walker must be reset by the same rst_i.
//  Assertions: req_valid_o is onehot0; walk_req_o only in REQ; walk_valid_i never seen in REQ without gnt.
// TESTING
//  T1: port0 enable, paddr=0x8000_1000, store=1; gnt at cycle 1; valid+allow=1 at cycle 2.
//   -> walk_paddr_o=0x8000_1000; req_valid_o=01 and req_allow_o=01 at cycle 3; held until req_done_i[0], then IDLE.
//  T2: both ports enabled continuously; walker answers with allow=0 each time.
//   -> grant order 0,1,0,1; req_allow_o stays 0; never two req_valid_o bits set.
//  T3: flush_i while in WAIT; walk_valid_i arrives 4 cycles later.
//   -> state DRAIN, no req_valid_o pulse; IDLE after the discarded pulse.
//  T4: owner drops enable in REQ with gnt withheld 3 cycles.
//   -> walk_req_o stays high until gnt; then DRAIN; result discarded.
//  T5: in RESP, owner drops enable and withholds req_done_i 5 cycles.
//   -> req_valid_o/req_allow_o held 5 cycles; no new walk issued.
//  T6: rst_i asserted during WAIT.
//   -> all outputs 0 next cycle; rr_ptr=0; the next grant goes to port 0.

Source files
------------

// File: rtl/mptw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mptw_arbiter
//  Description : Round-robin arbiter sharing one MPT walker between the store
//                buffer (port 0) and the load unit (port 1). One walk is in
//                flight at a time. The result is held until the owner
//                consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mptw_arbiter #(
  parameter int NR_PORTS = 2,
  parameter int PLEN     = 56
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NR_PORTS-1:0]      req_enable_i,
  input  logic [NR_PORTS*PLEN-1:0] req_paddr_i,
  input  logic [NR_PORTS-1:0]      req_store_i,
  input  logic [NR_PORTS-1:0]      req_done_i,
  output logic [NR_PORTS-1:0]      req_valid_o,
  output logic [NR_PORTS-1:0]      req_allow_o,
  output logic                     walk_req_o,
  output logic [PLEN-1:0]          walk_paddr_o,
  output logic                     walk_store_o,
  input  logic                     walk_gnt_i,
  input  logic                     walk_valid_i,
  input  logic                     walk_allow_i
);

  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NR_PORTS - 1);
  localparam logic [PTR_W:0]   NR_PORTS_W = (PTR_W + 1)'(NR_PORTS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state_q,  state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q,  owner_d;
  logic             abort_q,  abort_d;
  logic             allow_q,  allow_d;
  logic             store_q,  store_d;
  logic [PLEN-1:0]  paddr_q,  paddr_d;

  logic [2*NR_PORTS-1:0] rot_en;
  logic [PTR_W:0]        pick_off;
  logic [PTR_W:0]        pick_sum;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic [PLEN-1:0]       pick_paddr;
  logic                  pick_store;
  logic                  owner_en;
  logic                  owner_done;
  logic [NR_PORTS-1:0]   owner_oh;
  logic                  abort_now;

  // Round-robin pick: first enabled port at or after rr_ptr, wrapping.
  always_comb begin
    rot_en   = {req_enable_i, req_enable_i} >> rr_ptr_q;
    pick_vld = 1'b0;
    pick_off = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (!pick_vld && rot_en[i]) begin
        pick_vld = 1'b1;
        pick_off = (PTR_W + 1)'(i);
      end
    end
    pick_sum = {1'b0, rr_ptr_q} + pick_off;
    if (pick_sum >= NR_PORTS_W) begin
      pick_sum = pick_sum - NR_PORTS_W;
    end
    pick_idx = pick_sum[PTR_W-1:0];
  end

  // Per-port muxing of the picked request and of the current owner's controls.
  always_comb begin
    pick_paddr = '0;
    pick_store = 1'b0;
    owner_en   = 1'b0;
    owner_done = 1'b0;
    owner_oh   = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        pick_paddr = req_paddr_i[i*PLEN +: PLEN];
        pick_store = req_store_i[i];
      end
      if (owner_q == PTR_W'(i)) begin
        owner_en    = req_enable_i[i];
        owner_done  = req_done_i[i];
        owner_oh[i] = 1'b1;
      end
    end
  end

  // A walk is abandoned once flushed or once its owner stops asking for it.
  assign abort_now = abort_q | flush_i | ~owner_en;

  // Next-state logic for the single-walk-in-flight FSM.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    abort_d  = abort_q;
    allow_d  = allow_q;
    store_d  = store_q;
    paddr_d  = paddr_q;
    case (state_q)
      S_IDLE: begin
        if (!flush_i && pick_vld) begin
          owner_d  = pick_idx;
          paddr_d  = pick_paddr;
          store_d  = pick_store;
          abort_d  = 1'b0;
          rr_ptr_d = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // The request is never retracted; an abort only decides where the
        // walker's eventual answer goes.
        if (walk_gnt_i) begin
          abort_d = 1'b0;
          if (walk_valid_i) begin
            if (abort_now) begin
              state_d = S_IDLE;
            end else begin
              allow_d = walk_allow_i;
              state_d = S_RESP;
            end
          end else begin
            state_d = abort_now ? S_DRAIN : S_WAIT;
          end
        end else begin
          abort_d = abort_now;
        end
      end
      S_WAIT: begin
        // A result arriving together with an abort is simply dropped, since
        // no further pulse would come to end a drain.
        if (walk_valid_i) begin
          if (flush_i || !owner_en) begin
            state_d = S_IDLE;
          end else begin
            allow_d = walk_allow_i;
            state_d = S_RESP;
          end
        end else if (flush_i || !owner_en) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: begin
        // Enable dropping here is normal: the store buffer lowers it on valid.
        if (owner_done || flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (walk_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      abort_q  <= 1'b0;
      allow_q  <= 1'b0;
      store_q  <= 1'b0;
      paddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      abort_q  <= abort_d;
      allow_q  <= allow_d;
      store_q  <= store_d;
      paddr_q  <= paddr_d;
    end
  end

  assign walk_req_o   = (state_q == S_REQ);
  assign walk_paddr_o = paddr_q;
  assign walk_store_o = store_q;
  assign req_valid_o  = (state_q == S_RESP) ? owner_oh : '0;
  assign req_allow_o  = (state_q == S_RESP && allow_q) ? owner_oh : '0;

  a_valid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_valid_o));
  a_walk_req_in_req : assert property (@(posedge clk_i) disable iff (rst_i)
    walk_req_o |-> (state_q == S_REQ));
  a_no_valid_without_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
    ((state_q == S_REQ) && walk_valid_i) |-> walk_gnt_i);

endmodule
`default_nettype wire

// File: tb/tb_mptw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mptw_arbiter
//  Description : Directed scoreboard bench for mptw_arbiter. Stimulus pushes
//                the expected (port, allow) of each walk result; a monitor
//                pops and compares whenever a new req_valid_o appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mptw_arbiter;

  localparam int NR_PORTS = 2;
  localparam int PLEN     = 56;

  logic                     clk_i = 1'b0;
  logic                     rst_i;
  logic                     flush_i;
  logic [NR_PORTS-1:0]      req_enable_i;
  logic [NR_PORTS*PLEN-1:0] req_paddr_i;
  logic [NR_PORTS-1:0]      req_store_i;
  logic [NR_PORTS-1:0]      req_done_i;
  logic [NR_PORTS-1:0]      req_valid_o;
  logic [NR_PORTS-1:0]      req_allow_o;
  logic                     walk_req_o;
  logic [PLEN-1:0]          walk_paddr_o;
  logic                     walk_store_o;
  logic                     walk_gnt_i;
  logic                     walk_valid_i;
  logic                     walk_allow_i;

  mptw_arbiter #(.NR_PORTS(NR_PORTS), .PLEN(PLEN)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .req_enable_i (req_enable_i),
    .req_paddr_i  (req_paddr_i),
    .req_store_i  (req_store_i),
    .req_done_i   (req_done_i),
    .req_valid_o  (req_valid_o),
    .req_allow_o  (req_allow_o),
    .walk_req_o   (walk_req_o),
    .walk_paddr_o (walk_paddr_o),
    .walk_store_o (walk_store_o),
    .walk_gnt_i   (walk_gnt_i),
    .walk_valid_i (walk_valid_i),
    .walk_allow_i (walk_allow_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int port;
    bit allow;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int p, input bit a);
    exp_t e;
    e.port  = p;
    e.allow = a;
    sb.push_back(e);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (walk_req_o !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk(name, 64'(walk_req_o), 64'd1);
  endtask

  // Monitor: every fresh response is matched against the scoreboard.
  initial begin
    logic [NR_PORTS-1:0] prev_valid;
    exp_t                e;
    logic [63:0]         oh;
    prev_valid = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_valid = '0;
      end else begin
        chk("valid_onehot0", 64'($onehot0(req_valid_o)), 64'd1);
        if (req_valid_o != '0 && prev_valid == '0) begin
          if (sb.size() == 0) begin
            chk("resp_unexpected", 64'(req_valid_o), 64'd0);
          end else begin
            e  = sb.pop_front();
            oh = 64'd1 << e.port;
            chk("resp_port", 64'(req_valid_o), oh);
            chk("resp_allow", 64'(req_allow_o), e.allow ? oh : 64'd0);
          end
        end
        prev_valid = req_valid_o;
      end
    end
  end

  initial begin
    int p;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    req_enable_i = '0;
    req_paddr_i  = '0;
    req_store_i  = '0;
    req_done_i   = '0;
    walk_gnt_i   = 1'b0;
    walk_valid_i = 1'b0;
    walk_allow_i = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_valid", 64'(req_valid_o), 64'd0);
    chk("rst_allow", 64'(req_allow_o), 64'd0);
    chk("rst_walk_req", 64'(walk_req_o), 64'd0);
    chk("rst_paddr", 64'(walk_paddr_o), 64'd0);
    chk("rst_store", 64'(walk_store_o), 64'd0);
    rst_i = 1'b0;

    // T1: single store walk, gnt then valid one cycle later
    req_paddr_i[0 +: PLEN] = 56'h8000_1000;
    req_store_i  = 2'b01;
    req_enable_i = 2'b01;
    cyc();
    chk("t1_walk_req", 64'(walk_req_o), 64'd1);
    chk("t1_paddr", 64'(walk_paddr_o), 64'h8000_1000);
    chk("t1_store", 64'(walk_store_o), 64'd1);
    walk_gnt_i = 1'b1;
    cyc();
    walk_gnt_i   = 1'b0;
    walk_valid_i = 1'b1;
    walk_allow_i = 1'b1;
    push(0, 1'b1);
    cyc();
    walk_valid_i = 1'b0;
    walk_allow_i = 1'b0;
    chk("t1_valid_cycle3", 64'(req_valid_o), 64'h1);
    chk("t1_allow_cycle3", 64'(req_allow_o), 64'h1);
    req_done_i = 2'b10;
    cyc();
    req_done_i = 2'b00;
    chk("t1_nonowner_done", 64'(req_valid_o), 64'h1);
    repeat (2) cyc();
    chk("t1_hold", 64'(req_valid_o), 64'h1);
    req_done_i   = 2'b01;
    req_enable_i = 2'b00;
    cyc();
    req_done_i = 2'b00;
    chk("t1_release", 64'(req_valid_o), 64'h0);
    walk_valid_i = 1'b1;
    cyc();
    walk_valid_i = 1'b0;
    cyc();
    chk("t1_idle_valid_ignored", 64'(req_valid_o), 64'h0);
    chk("t1_idle_no_req", 64'(walk_req_o), 64'h0);

    // T2: both ports continuously, allow=0; grants rotate 0,1,0,1
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    req_paddr_i  = {56'h2000, 56'h1000};
    req_store_i  = 2'b00;
    req_enable_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      p = k % 2;
      wait_req("t2_walk_req");
      chk("t2_grant_paddr", 64'(walk_paddr_o), (p == 1) ? 64'h2000 : 64'h1000);
      push(p, 1'b0);
      walk_gnt_i   = 1'b1;
      walk_valid_i = 1'b1;
      walk_allow_i = 1'b0;
      cyc();
      walk_gnt_i   = 1'b0;
      walk_valid_i = 1'b0;
      chk("t2_allow_low", 64'(req_allow_o), 64'h0);
      req_done_i = 2'b01 << p;
      cyc();
      req_done_i = 2'b00;
    end
    req_enable_i = 2'b00;

    // T3: flush in WAIT, result arrives 4 cycles later and is discarded
    req_paddr_i[0 +: PLEN] = 56'h3000;
    req_enable_i = 2'b01;
    cyc();
    chk("t3_walk_req", 64'(walk_req_o), 64'd1);
    walk_gnt_i = 1'b1;
    cyc();
    walk_gnt_i   = 1'b0;
    flush_i      = 1'b1;
    req_enable_i = 2'b00;
    cyc();
    flush_i = 1'b0;
    repeat (3) begin
      chk("t3_drain_no_req", 64'(walk_req_o), 64'd0);
      cyc();
    end
    walk_valid_i = 1'b1;
    walk_allow_i = 1'b1;
    cyc();
    walk_valid_i = 1'b0;
    walk_allow_i = 1'b0;

    // T4: owner drops enable in REQ, gnt withheld 3 cycles
    req_paddr_i[PLEN +: PLEN] = 56'h4000;
    req_enable_i = 2'b10;
    cyc();
    chk("t3_idle_after_discard", 64'(walk_req_o), 64'd1);
    chk("t4_paddr", 64'(walk_paddr_o), 64'h4000);
    req_enable_i = 2'b00;
    repeat (3) begin
      cyc();
      chk("t4_req_held", 64'(walk_req_o), 64'd1);
    end
    walk_gnt_i = 1'b1;
    cyc();
    walk_gnt_i = 1'b0;
    chk("t4_drain_no_req", 64'(walk_req_o), 64'd0);
    walk_valid_i = 1'b1;
    walk_allow_i = 1'b1;
    cyc();
    walk_valid_i = 1'b0;
    walk_allow_i = 1'b0;

    // T5: in RESP the owner drops enable and withholds done for 5 cycles
    req_paddr_i[0 +: PLEN] = 56'h5000;
    req_enable_i = 2'b01;
    cyc();
    chk("t4_idle_after_discard", 64'(walk_req_o), 64'd1);
    walk_gnt_i = 1'b1;
    cyc();
    walk_gnt_i   = 1'b0;
    walk_valid_i = 1'b1;
    walk_allow_i = 1'b1;
    push(0, 1'b1);
    cyc();
    walk_valid_i = 1'b0;
    walk_allow_i = 1'b0;
    req_enable_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid_held", 64'(req_valid_o), 64'h1);
      chk("t5_allow_held", 64'(req_allow_o), 64'h1);
      chk("t5_no_new_walk", 64'(walk_req_o), 64'h0);
      if (i < 4) cyc();
    end
    req_done_i = 2'b01;
    cyc();
    req_done_i = 2'b00;
    chk("t5_release", 64'(req_valid_o), 64'h0);

    // T6: reset during WAIT; rr_ptr points at port 1 beforehand
    req_paddr_i[0 +: PLEN] = 56'h6000;
    req_store_i  = 2'b01;
    req_enable_i = 2'b01;
    cyc();
    chk("t6_walk_req", 64'(walk_req_o), 64'd1);
    walk_gnt_i = 1'b1;
    cyc();
    walk_gnt_i   = 1'b0;
    rst_i        = 1'b1;
    req_enable_i = 2'b00;
    cyc();
    chk("t6_rst_valid", 64'(req_valid_o), 64'd0);
    chk("t6_rst_allow", 64'(req_allow_o), 64'd0);
    chk("t6_rst_walk_req", 64'(walk_req_o), 64'd0);
    chk("t6_rst_paddr", 64'(walk_paddr_o), 64'd0);
    chk("t6_rst_store", 64'(walk_store_o), 64'd0);
    rst_i        = 1'b0;
    req_store_i  = 2'b00;
    req_paddr_i  = {56'h7100, 56'h7000};
    req_enable_i = 2'b11;
    cyc();
    chk("t6_regrant_req", 64'(walk_req_o), 64'd1);
    chk("t6_regrant_port0", 64'(walk_paddr_o), 64'h7000);
    walk_gnt_i   = 1'b1;
    walk_valid_i = 1'b1;
    walk_allow_i = 1'b1;
    push(0, 1'b1);
    cyc();
    walk_gnt_i   = 1'b0;
    walk_valid_i = 1'b0;
    walk_allow_i = 1'b0;
    req_done_i   = 2'b01;
    req_enable_i = 2'b00;
    cyc();
    req_done_i = 2'b00;

    // T7: flush in IDLE blocks one grant; done+flush together in RESP
    req_enable_i = 2'b10;
    flush_i      = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("t7_flush_blocks_grant", 64'(walk_req_o), 64'd0);
    cyc();
    chk("t7_grant_after_flush", 64'(walk_req_o), 64'd1);
    chk("t7_paddr_port1", 64'(walk_paddr_o), 64'h7100);
    walk_gnt_i   = 1'b1;
    walk_valid_i = 1'b1;
    walk_allow_i = 1'b0;
    push(1, 1'b0);
    cyc();
    walk_gnt_i   = 1'b0;
    walk_valid_i = 1'b0;
    chk("t7_resp_port1", 64'(req_valid_o), 64'h2);
    req_enable_i = 2'b00;
    req_done_i   = 2'b10;
    flush_i      = 1'b1;
    cyc();
    req_done_i = 2'b00;
    flush_i    = 1'b0;
    chk("t7_done_flush_release", 64'(req_valid_o), 64'h0);
    cyc();
    chk("t7_idle_no_req", 64'(walk_req_o), 64'h0);

    repeat (3) cyc();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
